// File: rtl/int_to_ieee754_if.sv
// Operand/result bundle for the Q32.32 to IEEE 754 single-precision converter.
interface int_to_ieee754_if;
    logic [31:0] left_hand_side;
    logic [31:0] right_hand_side;
    logic [31:0] result;

    modport master (
        output left_hand_side,
        output right_hand_side,
        input  result
    );

    modport slave (
        input  left_hand_side,
        input  right_hand_side,
        output result
    );
endinterface

// File: rtl/int_to_ieee754.sv
// Signed Q32.32 fixed-point to IEEE 754 single precision, round-to-nearest-even.
// Purely combinational conversion followed by a single output register.
module int_to_ieee754 (
    input  logic               clk,
    input  logic               rst,
    int_to_ieee754_if.slave    bus
);
    localparam int unsigned W_FIX   = 64;
    localparam int unsigned W_POS   = 6;
    localparam int unsigned W_EXP   = 8;
    localparam int unsigned W_FRAC  = 23;
    localparam int unsigned EXP_OFS = 95;   // bias 127 minus the 32 fraction bits

    typedef struct packed {
        logic              sign;
        logic [W_EXP-1:0]  exp;
        logic [W_FRAC-1:0] frac;
    } ieee754_sp_t;

    logic [W_FIX-1:0]  operand;
    logic              sgn;
    logic [W_FIX-1:0]  mag;
    logic [W_POS-1:0]  lead_pos;
    logic [W_FIX-1:0]  norm;
    logic              is_zero;
    logic [W_FRAC-1:0] frac_trunc;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [W_FRAC:0]   frac_sum;
    logic [W_EXP-1:0]  exp_adj;
    ieee754_sp_t       result_d;
    ieee754_sp_t       result_q;

    // Magnitude of the two's-complement operand; 2^63 stays exact as unsigned.
    always_comb begin
        operand = {bus.left_hand_side, bus.right_hand_side};
        sgn     = operand[W_FIX-1];
        mag     = sgn ? (~operand + W_FIX'(1)) : operand;
    end

    // Leading-one position: highest set bit wins.
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < int'(W_FIX); i++) begin
            if (mag[i]) lead_pos = W_POS'(i);
        end
    end

    // Left-justify so the hidden bit sits at the MSB; short values zero-pad below.
    always_comb begin
        norm       = mag << (W_POS'(W_FIX - 1) - lead_pos);
        is_zero    = ~norm[W_FIX-1];
        frac_trunc = norm[W_FIX-2 -: W_FRAC];
        guard      = norm[W_FIX-2-W_FRAC];
        sticky     = |norm[W_FIX-3-W_FRAC:0];
    end

    // Round-to-nearest-even; a fraction carry bumps the exponent (max 159, no overflow).
    always_comb begin
        round_up = guard & (sticky | frac_trunc[0]);
        frac_sum = {1'b0, frac_trunc} + (W_FRAC+1)'(round_up);
        exp_adj  = W_EXP'(lead_pos) + W_EXP'(EXP_OFS) + W_EXP'(frac_sum[W_FRAC]);
    end

    always_comb begin
        result_d = '0;
        if (!is_zero) begin
            result_d.sign = sgn;
            result_d.exp  = exp_adj;
            result_d.frac = frac_sum[W_FRAC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) result_q <= '0;
        else     result_q <= result_d;
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_int_to_ieee754.sv
// Directed and randomized check of int_to_ieee754 against an integer-arithmetic
// reference that rounds by comparing the discarded remainder with one half ULP.
module tb_int_to_ieee754;
    logic clk;
    logic rst;
    int_to_ieee754_if bus ();

    int_to_ieee754 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_val;
    bit          exp_valid;
    string       exp_tag;

    // Exact 64-bit signed value times 2^-32, rounded to single precision (RNE).
    function automatic logic [31:0] ref_float(input logic [31:0] l, input logic [31:0] r);
        logic [63:0] v;
        logic [63:0] m;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        logic        s;
        int          k;
        int          e;
        v = {l, r};
        if (v == 64'd0) return 32'h0;
        s = v[63];
        m = s ? (64'd0 - v) : v;
        if (m < 64'h100_0000) begin
            k = 0;
            q = m;
            while (q < 64'h80_0000) begin
                q = q << 1;
                k++;
            end
            e = 118 - k;
        end else begin
            k = 0;
            while ((m >> k) >= 64'h100_0000) k++;
            q    = m >> k;
            rem  = m - (q << k);
            half = 64'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                k++;
            end
            e = 118 + k;
        end
        return {s, 8'(e), q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] expected);
        n_vec++;
        assert (bus.result === expected)
        else begin
            n_err++;
            $error("FAIL %s: result=%h expected=%h", tag, bus.result, expected);
        end
    endtask

    // Each negedge checks the previous cycle's expectation, then drives the next operand.
    task automatic step(input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] e, input string tag);
        @(negedge clk);
        if (exp_valid) check(exp_tag, exp_val);
        bus.left_hand_side  = l;
        bus.right_hand_side = r;
        exp_val   = e;
        exp_tag   = tag;
        exp_valid = 1'b1;
    endtask

    task automatic flush();
        @(negedge clk);
        if (exp_valid) check(exp_tag, exp_val);
        exp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] l;
        logic [31:0] r;
        n_vec     = 0;
        n_err     = 0;
        exp_valid = 1'b0;
        exp_val   = '0;
        exp_tag   = "";
        rst       = 1'b1;
        bus.left_hand_side  = 32'd3;
        bus.right_hand_side = 32'd0;

        // Reset overrides the converted value, then the first free edge loads it.
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", 32'h0000_0000);
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_3", 32'h4040_0000);
        @(negedge clk);
        check("constant_3", 32'h4040_0000);

        // Back-to-back directed vectors, one result per edge.
        step(32'hFFFF_FFFF, 32'h0000_0000, 32'hBF80_0000, "neg_one");
        step(32'hFFFF_FF82, 32'h0000_0000, 32'hC2FC_0000, "neg_126");
        step(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero");
        step(32'h8000_0000, 32'h0000_0000, 32'hCF00_0000, "min_neg");
        step(32'h0000_0000, 32'h8000_0000, 32'h3F00_0000, "half");
        step(32'hFFFF_FFFF, 32'h8000_0000, 32'hBF00_0000, "neg_half");
        step(32'h0000_0000, 32'h0000_0001, 32'h2F80_0000, "lsb_frac");
        step(32'h0100_0001, 32'h0000_0000, 32'h4B80_0000, "tie_even");
        step(32'h0100_0003, 32'h0000_0000, 32'h4B80_0002, "tie_up");
        step(32'h7FFF_FFFF, 32'h0000_0000, 32'h4F00_0000, "exp_carry");
        step(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h4F00_0000, "max_pos");
        step(32'h0000_0003, 32'h0000_0000, 32'h4040_0000, "three");

        // Reset mid-stream discards the operand sampled under reset.
        @(negedge clk);
        check(exp_tag, exp_val);
        exp_valid = 1'b0;
        rst = 1'b1;
        bus.left_hand_side  = 32'h0100_0003;
        bus.right_hand_side = 32'h0000_0000;
        @(negedge clk);
        check("mid_reset", 32'h0000_0000);
        rst = 1'b0;
        exp_val   = 32'h4B80_0002;
        exp_tag   = "post_mid_reset";
        exp_valid = 1'b1;

        // Randomized operands from several value classes.
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 4))
                0: begin l = $urandom(); r = $urandom(); end
                1: begin l = 32'($signed(8'($urandom()))); r = 32'd0; end
                2: begin l = {32{$urandom_range(0, 1) == 1}}; r = $urandom() >> $urandom_range(0, 31); end
                3: begin l = $urandom() >> $urandom_range(0, 31); r = $urandom() & 32'hFF; end
                default: begin l = $urandom() | 32'h00FF_FFFF; r = $urandom(); end
            endcase
            step(l, r, ref_float(l, r), "random");
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
